// File: rtl/if_pc_gen_pkg.sv
// if_pc_gen shared types: FSM states, reset PC, NOP encoding.
// Default widths for `XLEN / `INSTR_WIDTH when the core has not set them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package if_pc_gen_pkg;

  typedef enum logic [1:0] {
    IF_ST_REQ  = 2'd0,
    IF_ST_WAIT = 2'd1,
    IF_ST_HOLD = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_NOP      = 32'h0000_0013;

endpackage

// File: rtl/if_pc_gen_if.sv
// Instruction-memory request/response channel of the fetch stage.
// One request in flight at a time; one response per accepted request.
interface if_pc_gen_if #(
  parameter int XLEN = `XLEN,
  parameter int IW   = `INSTR_WIDTH
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_instr;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_instr
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_instr
  );
endinterface

// File: rtl/if_next_pc.sv
// Static next-PC predictor: jal/jalr always taken, branches per BTFN.
// Backward-taken branch prediction is enabled by IF_STATIC_BPRED_EN.
module if_next_pc
  import if_pc_gen_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] npc,
  output logic            taken
);

  logic br_taken;

`ifdef IF_STATIC_BPRED_EN
  assign br_taken = imm[XLEN-1];
`else
  assign br_taken = 1'b0;
`endif

  always_comb begin
    npc   = pc + XLEN'(4);
    taken = 1'b0;
    unique case (1'b1)
      jal: begin
        npc   = pc + imm;
        taken = 1'b1;
      end
      jalr: begin
        npc   = (rs1 + imm) & ~XLEN'(1);
        taken = 1'b1;
      end
      branch: begin
        if (br_taken) begin
          npc   = pc + imm;
          taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC register and REQ/WAIT/HOLD sequencer of the IF stage.
// Optional BTFN branch prediction: define IF_STATIC_BPRED_EN.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int              XLEN     = `XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  if_pc_gen_if.master             imem,
  output logic [`INSTR_WIDTH-1:0] if_instr_o,
  output logic [XLEN-1:0]         if_pc_o,
  output logic                    if_valid_o,
  input  logic                    id_ready_i,
  output logic                    if_pred_taken_o,
  input  logic                    mini_dec_jal_i,
  input  logic                    mini_dec_jalr_i,
  input  logic                    mini_dec_branch_i,
  input  logic [4:0]              mini_dec_jalr_rs1_idx_i,
  input  logic [XLEN-1:0]         mini_dec_imm_i,
  input  logic [XLEN-1:0]         jalr_rs1_rdata_i,
  input  logic                    jalr_rs1_busy_i,
  input  logic                    exu_redirect_i,
  input  logic [XLEN-1:0]         exu_redirect_pc_i
);

  if_state_e               state_q;
  logic [XLEN-1:0]         pc_q;
  logic [`INSTR_WIDTH-1:0] instr_q;
  logic                    req_vld_q;
  logic                    stale_q;
  logic [XLEN-1:0]         npc;
  logic                    taken;
  logic                    stall;
  logic                    req_fire;
  logic                    id_fire;
  logic                    rsp_lost;

  if_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc     (pc_q),
    .jal    (mini_dec_jal_i),
    .jalr   (mini_dec_jalr_i),
    .branch (mini_dec_branch_i),
    .imm    (mini_dec_imm_i),
    .rs1    (jalr_rs1_rdata_i),
    .npc    (npc),
    .taken  (taken)
  );

  // x0 is hardwired, so a busy flag on it never blocks a jalr.
  assign stall = mini_dec_jalr_i & jalr_rs1_busy_i
               & (mini_dec_jalr_rs1_idx_i != 5'd0);

  assign if_valid_o      = (state_q == IF_ST_HOLD) & ~stall;
  assign if_pred_taken_o = if_valid_o & taken;
  assign if_pc_o         = pc_q;
  assign if_instr_o      = instr_q;
  assign id_fire         = if_valid_o & id_ready_i;

  assign imem.req_valid  = req_vld_q;
  assign imem.req_addr   = pc_q;
  assign req_fire        = req_vld_q & imem.req_ready;

  // A response is owed but not arriving: it must be dropped later.
  assign rsp_lost = req_fire
                  | ((state_q == IF_ST_WAIT) & ~imem.rsp_valid);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IF_ST_REQ;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      req_vld_q <= 1'b0;
      stale_q   <= 1'b0;
    end else if (exu_redirect_i) begin
      pc_q <= {exu_redirect_pc_i[XLEN-1:1], 1'b0};
      if (rsp_lost) begin
        state_q   <= IF_ST_WAIT;
        stale_q   <= 1'b1;
        req_vld_q <= 1'b0;
      end else begin
        state_q   <= IF_ST_REQ;
        stale_q   <= 1'b0;
        req_vld_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        IF_ST_REQ: begin
          if (req_fire) begin
            state_q   <= IF_ST_WAIT;
            req_vld_q <= 1'b0;
          end else begin
            req_vld_q <= 1'b1;
          end
        end
        IF_ST_WAIT: begin
          if (imem.rsp_valid) begin
            if (stale_q) begin
              stale_q   <= 1'b0;
              state_q   <= IF_ST_REQ;
              req_vld_q <= 1'b1;
            end else begin
              instr_q <= imem.rsp_instr;
              state_q <= IF_ST_HOLD;
            end
          end
        end
        IF_ST_HOLD: begin
          if (id_fire) begin
            pc_q      <= npc;
            state_q   <= IF_ST_REQ;
            req_vld_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IF_ST_REQ;
          req_vld_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: directed program plus randomized memory/ID/redirect
// traffic, checked every cycle against a PC-sequence reference model.
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  localparam logic [31:0] K = 32'h5A5A_0013;
`ifdef IF_STATIC_BPRED_EN
  localparam logic [31:0] BEQ_NEXT = 32'h38;
`else
  localparam logic [31:0] BEQ_NEXT = 32'h44;
`endif

  typedef struct packed {
    logic        jal;
    logic        jalr;
    logic        br;
    logic [4:0]  rs1;
    logic [31:0] imm;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic        if_valid, if_taken, id_ready;
  logic        dec_jal, dec_jalr, dec_br, rs1_busy;
  logic [4:0]  dec_rs1;
  logic [31:0] dec_imm, rs1_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  if_pc_gen_if imem ();

  if_pc_gen dut (
    .clk_i                   (clk),
    .rst_n_i                 (rst_n),
    .imem                    (imem),
    .if_instr_o              (if_instr),
    .if_pc_o                 (if_pc),
    .if_valid_o              (if_valid),
    .id_ready_i              (id_ready),
    .if_pred_taken_o         (if_taken),
    .mini_dec_jal_i          (dec_jal),
    .mini_dec_jalr_i         (dec_jalr),
    .mini_dec_branch_i       (dec_br),
    .mini_dec_jalr_rs1_idx_i (dec_rs1),
    .mini_dec_imm_i          (dec_imm),
    .jalr_rs1_rdata_i        (rs1_rdata),
    .jalr_rs1_busy_i         (rs1_busy),
    .exu_redirect_i          (redirect),
    .exu_redirect_pc_i       (redirect_pc)
  );

  int n_chk = 0;
  int n_fail = 0;

  dec_t        prog [logic [31:0]];
  bit          rand_prog = 0;
  logic [31:0] seed = 32'h1234_5678;
  logic [31:0] regs [32];

  logic [31:0] exp_pc = 32'h0;
  logic [31:0] acc_q [$];
  logic [32:0] ho_q [$];
  int          n_ho = 0;

  bit          outst = 0;
  logic [31:0] out_addr = 32'h0;
  int          wcnt = 0;
  int          lat_lo = 0, lat_hi = 0;
  bit          ready_always = 1, idr_always = 1, redir_rand = 0;
  int          busy_mode = 0;
  bit          redir_arm = 0, redir_go = 0;
  logic [31:0] redir_tgt = 32'h0;

  function automatic logic [31:0] word(logic [31:0] a);
    return a ^ K;
  endfunction

  function automatic dec_t decode(logic [31:0] a);
    dec_t d;
    logic [31:0] h;
    d = '0;
    if (prog.exists(a)) return prog[a];
    if (!rand_prog) return d;
    h = (a ^ seed) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    d.imm = {{20{h[31]}}, h[27:18], 2'b00};
    d.rs1 = h[9:5];
    case (h[3:0])
      4'd0, 4'd1:       d.jal  = 1'b1;
      4'd2, 4'd3, 4'd4: d.br   = 1'b1;
      4'd5, 4'd6:       d.jalr = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  // Architectural next PC and predicted-taken flag of the instruction at pc.
  function automatic logic [32:0] exp_next(logic [31:0] pc, dec_t d);
    logic [31:0] base;
    base = (d.rs1 == 5'd0) ? 32'h0 : regs[d.rs1];
    if (d.jal) return {1'b1, pc + d.imm};
    if (d.jalr) return {1'b1, (base + d.imm) & 32'hFFFF_FFFE};
`ifdef IF_STATIC_BPRED_EN
    if (d.br && d.imm[31]) return {1'b1, pc + d.imm};
`endif
    return {1'b0, pc + 32'd4};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  task automatic drive();
    dec_t d;
    imem.req_ready = ready_always ? 1'b1 : ($urandom_range(3, 0) != 0);
    if (outst && wcnt == 0) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_instr = word(out_addr);
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_instr = $urandom;
      if (outst) wcnt--;
    end
    id_ready = idr_always ? 1'b1 : ($urandom_range(3, 0) != 0);
    case (busy_mode)
      0:       rs1_busy = 1'b0;
      1:       rs1_busy = 1'b1;
      default: rs1_busy = ($urandom_range(1, 0) != 0);
    endcase
    redirect = 1'b0;
    redirect_pc = $urandom;
    if (redir_go) begin
      redirect = 1'b1;
      redirect_pc = redir_tgt;
      redir_go = 0;
    end else if (redir_rand && $urandom_range(31, 0) == 0) begin
      redirect = 1'b1;
    end
    d = decode(if_instr ^ K);
    dec_jal   = d.jal;
    dec_jalr  = d.jalr;
    dec_br    = d.br;
    dec_rs1   = d.rs1;
    dec_imm   = d.imm;
    rs1_rdata = (d.rs1 == 5'd0) ? 32'h0 : regs[d.rs1];
  endtask

  // One clock: compare at the falling edge, advance the model, drive inputs.
  task automatic cycle();
    dec_t        d;
    logic [32:0] nx;
    bit          acc, ho;
    @(negedge clk);
    if (rst_n) begin
      d  = decode(exp_pc);
      nx = exp_next(exp_pc, d);
      if (imem.req_valid) chk("req_addr", imem.req_addr, exp_pc);
      if (if_valid) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, word(exp_pc));
        chk("pred_taken", {31'h0, if_taken}, {31'h0, nx[32]});
      end
      if (d.jalr && rs1_busy && d.rs1 != 5'd0 &&
          if_pc == exp_pc && if_instr == word(exp_pc))
        chk("jalr_stall", {31'h0, if_valid}, 32'h0);
      acc = imem.req_valid & imem.req_ready;
      ho  = if_valid & id_ready;
      if (acc) acc_q.push_back(imem.req_addr);
      if (ho) begin
        ho_q.push_back({if_taken, if_pc});
        n_ho++;
      end
      if (redirect) exp_pc = {redirect_pc[31:1], 1'b0};
      else if (ho) exp_pc = nx[31:0];
      if (imem.rsp_valid) outst = 0;
      if (acc) begin
        outst = 1;
        out_addr = imem.req_addr;
        wcnt = $urandom_range(lat_hi, lat_lo);
        if (redir_arm) begin
          redir_go = 1;
          redir_arm = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_acc(input string nm, output logic [31:0] a);
    a = 32'hDEAD_BEEF;
    for (int i = 0; i < 100; i++) begin
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        return;
      end
      cycle();
    end
    timeout(nm);
  endtask

  task automatic run_to_ho(input string nm, input logic [31:0] pc,
                           output logic taken);
    logic [32:0] e;
    taken = 1'bx;
    for (int i = 0; i < 400; i++) begin
      while (ho_q.size() > 0) begin
        e = ho_q.pop_front();
        if (e[31:0] == pc) begin
          taken = e[32];
          acc_q.delete();
          return;
        end
      end
      cycle();
    end
    timeout(nm);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_req_valid"}, {31'h0, imem.req_valid}, 32'h0);
    chk({nm, "_req_addr"}, imem.req_addr, IF_RESET_PC);
    chk({nm, "_if_valid"}, {31'h0, if_valid}, 32'h0);
    chk({nm, "_taken"}, {31'h0, if_taken}, 32'h0);
    chk({nm, "_instr"}, if_instr, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        t;
    int          lows;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'h101;
    prog[32'h10] = '{jal: 1'b1, jalr: 1'b0, br: 1'b0, rs1: 5'd0, imm: 32'h20};
    prog[32'h30] = '{jal: 1'b1, jalr: 1'b0, br: 1'b0, rs1: 5'd0, imm: 32'h10};
    prog[32'h40] = '{jal: 1'b0, jalr: 1'b0, br: 1'b1, rs1: 5'd0, imm: -32'sd8};
    prog[32'h3c] = '{jal: 1'b1, jalr: 1'b0, br: 1'b0, rs1: 5'd0, imm: 32'h44};
    prog[32'h44] = '{jal: 1'b1, jalr: 1'b0, br: 1'b0, rs1: 5'd0, imm: 32'h3c};
    prog[32'h80] = '{jal: 1'b0, jalr: 1'b1, br: 1'b0, rs1: 5'd5, imm: 32'h4};
    drive();

    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    #1;
    rst_n = 1'b1;

    // Straight-line stream from RESET_PC
    wait_acc("first_acc", a);
    chk("first_req_addr", a, 32'h0);
    for (int i = 0; i < 400 && ho_q.size() < 3; i++) cycle();
    if (ho_q.size() < 3) timeout("seq_handoffs");
    else begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_pc", ho_q[i][31:0], 32'(4 * i));
        chk("seq_taken", {31'h0, ho_q[i][32]}, 32'h0);
      end
    end

    // jal at 0x10, then beq at 0x40
    run_to_ho("jal_ho", 32'h10, t);
    chk("jal_taken", {31'h0, t}, 32'h1);
    wait_acc("jal_acc", a);
    chk("jal_target", a, 32'h30);
    run_to_ho("beq_ho", 32'h40, t);
    wait_acc("beq_acc", a);
    chk("beq_target", a, BEQ_NEXT);

    // jalr with busy base register for three HOLD cycles
    busy_mode = 1;
    lows = -1;
    for (int i = 0; i < 400; i++) begin
      cycle();
      #1;
      if (if_pc == 32'h80 && if_instr == word(32'h80)) begin
        lows = 0;
        break;
      end
    end
    if (lows < 0) timeout("jalr_hold");
    else begin
      for (int i = 0; i < 3; i++) begin
        if (!if_valid) lows++;
        if (i == 2) busy_mode = 0;
        cycle();
        #1;
      end
      chk("jalr_stall_cycles", 32'(lows), 32'd3);
      chk("jalr_release_valid", {31'h0, if_valid}, 32'h1);
    end
    acc_q.delete();
    wait_acc("jalr_acc", a);
    chk("jalr_target", a, 32'h104);

    // Redirect while waiting for a late response
    lat_lo = 2;
    lat_hi = 2;
    redir_tgt = 32'h200;
    redir_arm = 1;
    wait_acc("redir_wait_arm", a);
    wait_acc("redir_wait_acc", a);
    chk("redir_wait_target", a, 32'h200);
    run_to_ho("redir_wait_ho", 32'h200, t);

    // Redirect coincident with the response, misaligned target
    lat_lo = 0;
    lat_hi = 0;
    redir_tgt = 32'h303;
    redir_arm = 1;
    wait_acc("redir_rsp_arm", a);
    wait_acc("redir_rsp_acc", a);
    chk("redir_rsp_target", a, 32'h302);
    run_to_ho("redir_rsp_ho", 32'h302, t);

    // Asynchronous reset while a response is outstanding
    lat_lo = 3;
    lat_hi = 3;
    wait_acc("mid_wait_acc", a);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    outst = 0;
    redir_arm = 0;
    redir_go = 0;
    exp_pc = IF_RESET_PC;
    lat_lo = 0;
    lat_hi = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    acc_q.delete();
    ho_q.delete();
    wait_acc("restart_acc", a);
    chk("restart_addr", a, IF_RESET_PC);

    // Randomized program and traffic
    rand_prog = 1;
    seed = $urandom;
    ready_always = 0;
    idr_always = 0;
    busy_mode = 2;
    redir_rand = 1;
    lat_lo = 0;
    lat_hi = 3;
    n_ho = 0;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      acc_q.delete();
      ho_q.delete();
    end
    n_chk++;
    if (n_ho < 100) begin
      n_fail++;
      $display("FAIL random_progress: got %0d handoffs expected >= 100", n_ho);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Fetch-stage PC register, fetch sequencer and static next-PC predictor of the single-issue core.
- Issues one instruction-memory request at a time and returns the fetched word to the IF mini decoder and to ID.
- Consumes the mini decoder's jal/jalr/branch/rs1-index/immediate outputs to choose the next PC; an execute-stage redirect overrides everything.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- XLEN, `XLEN: PC and immediate width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  fetch address
- imem_rsp_valid_i  in  1  response valid, one per accepted request, at least one cycle later
- imem_rsp_instr_i  in  `INSTR_WIDTH  fetched word
- if_instr_o  out  `INSTR_WIDTH  held instruction, to mini decoder and ID
- if_pc_o  out  XLEN  PC of if_instr_o
- if_valid_o  out  1  instruction valid to ID
- id_ready_i  in  1  ID accepts instruction
- if_pred_taken_o  out  1  predicted-taken flag sent with the instruction
- mini_dec_jal_i / mini_dec_jalr_i / mini_dec_branch_i  in  1 each  from mini decoder
- mini_dec_jalr_rs1_idx_i  in  5  jalr base register
- mini_dec_imm_i  in  XLEN  decoded immediate
- jalr_rs1_rdata_i  in  XLEN  register-file read of mini_dec_jalr_rs1_idx_i
- jalr_rs1_busy_i  in  1  rs1 has an in-flight write
- exu_redirect_i  in  1  execute mispredict or trap redirect
- exu_redirect_pc_i  in  XLEN  redirect target

Behaviour:
Reset values:
- State REQ; pc = RESET_PC.
- imem_req_valid_o = 0 during reset, then 1 on the first cycle after reset.
- if_valid_o = 0; if_pred_taken_o = 0; if_instr_o = 0 (NOP not required); stale flag = 0.

States:
- REQ: imem_req_valid_o = 1, imem_req_addr_o = pc. On imem_req_ready_i, go to WAIT.
- WAIT: on imem_rsp_valid_i,
  - stale = 1: drop the word, clear stale, go to REQ.
  - otherwise: latch instr into if_instr_o, go to HOLD.
- HOLD: if_valid_o = 1 except during a jalr stall.
  - next_pc is computed combinationally from the mini decoder inputs and pc.
  - On if_valid_o & id_ready_i: pc <= next_pc, pred_taken latched, go to REQ.
  - The next request is issued in the following cycle (fetch bubble of 1; throughput is one instruction per 3 cycles minimum with a zero-latency memory).

Next-PC rules (XLEN-bit wrap-around add, no overflow detection):
- jal: pc + imm, taken = 1.
- branch: pc + imm when predicted taken (see optional feature), else pc + 4.
- jalr: (rs1 + imm) & ~1, taken = 1.
  - While jalr_rs1_busy_i = 1: if_valid_o = 0, stay in HOLD (jalr stall).
  - rs1 = x0 never stalls.
- otherwise: pc + 4, taken = 0.

Redirect (highest priority, any state):
- pc <= exu_redirect_pc_i; if_valid_o <= 0; next state REQ.
- If in WAIT with the response not arriving this cycle: stay in WAIT with stale = 1.
- If imem_rsp_valid_i arrives in the same cycle: discard it, go to REQ.
- If in REQ with imem_req_ready_i = 1 the same cycle: the request counts as accepted. Go to WAIT with stale = 1.
- Redirect and id_ready_i in the same cycle: redirect wins; the handed-off instruction is still consumed by ID.

Misaligned redirect target:
- Bit 1 is passed through unchanged; bit 0 is forced to 0.

Reset mid-operation:
- Asynchronous return to the reset state.
- An outstanding memory response after reset is not expected; the memory is reset by the same rst_n_i.

Optional Feature:
- Macro IF_STATIC_BPRED_EN.
- Defined: a branch is predicted taken iff mini_dec_imm_i[XLEN-1] = 1 (backward, BTFN).
- Undefined: every branch is predicted not-taken (pc + 4, taken = 0). jal and jalr are unaffected.

Decomposition:
- Shared defines: state encoding (IF_ST_REQ/WAIT/HOLD), RESET_PC default, NOP encoding. XLEN and INSTR_WIDTH are already there.
- One sub-module, if_next_pc: purely combinational next-PC and taken computation, including the ifdef.
- if_pc_gen holds the FSM and registers.

Test Plan:
- Reset release, memory ready = 1, response at +1 → first request addr 0x0 and a straight-line addi stream. PCs 0x0, 0x4, 0x8 are delivered to ID with taken = 0.
- jal at 0x10 with imm = 0x20 → next request addr 0x30, if_pred_taken_o = 1 at handoff.
- beq at 0x40 with imm = −8:
  - IF_STATIC_BPRED_EN defined → next addr 0x38.
  - Undefined → next addr 0x44.
- jalr with rs1 = x5 = 0x101, imm = 4, busy for 3 cycles → if_valid_o is low for 3 cycles, then next addr 0x104.
- Redirect to 0x200 while in WAIT → the late response is dropped, and the next request addr is 0x200. Then redirect coincident with the response → dropped, next addr is the redirect target.
- Assert rst_n_i mid-WAIT → all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
